// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state type, funct3 codes and size helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    // Unsigned variants only exist for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !we;
            default:          is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - beat address, byte enables, write lane steering and load extraction
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_beat,
    input  logic [DATA_W-1:0] i_word0,
    input  logic [DATA_W-1:0] i_word1,
    output logic              o_split,
    output logic [ADDR_W-1:0] o_beat_addr,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_beat_wdata,
    output logic [DATA_W-1:0] o_load_data
);

    logic [1:0]          w_off;
    logic [4:0]          w_shift;
    logic [2:0]          w_end;
    logic [7:0]          w_be_wide;
    logic [2*DATA_W-1:0] w_wdata_wide;
    logic [2*DATA_W-1:0] w_pair;
    logic                w_sign_b;
    logic                w_sign_h;

    assign w_off   = i_addr[1:0];
    assign w_shift = {w_off, 3'b000};
    assign w_end   = {1'b0, w_off} + size_bytes(i_funct3);
    assign o_split = (w_end > 3'd4);

    // Shifting into a double-width field puts beat 0 in the low half and beat 1 in the high half.
    assign w_be_wide    = {4'b0000, size_mask(i_funct3)} << w_off;
    assign w_wdata_wide = {{DATA_W{1'b0}}, i_wdata} << w_shift;

    assign o_be         = i_beat ? w_be_wide[7:4] : w_be_wide[3:0];
    assign o_beat_wdata = i_beat ? w_wdata_wide[2*DATA_W-1:DATA_W] : w_wdata_wide[DATA_W-1:0];
    assign o_beat_addr  = {i_addr[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, i_beat, 2'b00};

    assign w_pair   = {i_word1, i_word0} >> w_shift;
    assign w_sign_b = !i_funct3[2] && w_pair[7];
    assign w_sign_h = !i_funct3[2] && w_pair[15];

    always_comb begin
        o_load_data = w_pair[DATA_W-1:0];
        case (i_funct3[1:0])
            2'b00:   o_load_data = {{(DATA_W-8){w_sign_b}}, w_pair[7:0]};
            2'b01:   o_load_data = {{(DATA_W-16){w_sign_h}}, w_pair[15:0]};
            default: o_load_data = w_pair[DATA_W-1:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core-side load/store FSM driving a word-aligned req/gnt/rvalid memory port
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_core_valid,
    output logic              o_core_ready,
    input  logic              i_core_we,
    input  logic [2:0]        i_core_funct3,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_done,
    output logic              o_core_err,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_word0;
    logic [DATA_W-1:0] r_word1;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_legal;
    logic              w_req;
    logic              w_done;
    logic              w_split;
    logic [ADDR_W-1:0] w_beat_addr;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_beat_wdata;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_result;

    assign w_legal = is_legal(i_core_we, i_core_funct3);

    lsu_align #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3     (r_funct3),
        .i_addr       (r_addr),
        .i_wdata      (r_wdata),
        .i_beat       (r_state == S_REQ1),
        .i_word0      (r_word0),
        .i_word1      (r_word1),
        .o_split      (w_split),
        .o_beat_addr  (w_beat_addr),
        .o_be         (w_be),
        .o_beat_wdata (w_beat_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_core_ready = 1'b0;
        w_req        = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_core_ready = 1'b1;
                if (i_core_valid) begin
                    w_next = w_legal ? S_REQ0 : S_RESP;
                end
            end
            S_REQ0: begin
                w_req = 1'b1;
                if (i_mem_gnt) begin
                    if (!r_we)        w_next = S_WAIT0;
                    else if (w_split) w_next = S_REQ1;
                    else              w_next = S_RESP;
                end
            end
            S_WAIT0: begin
                if (i_mem_rvalid) begin
                    w_next = w_split ? S_REQ1 : S_RESP;
                end
            end
            S_REQ1: begin
                w_req = 1'b1;
                if (i_mem_gnt) begin
                    w_next = r_we ? S_RESP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (i_mem_rvalid) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word0  <= '0;
            r_word1  <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (r_state == S_IDLE && i_core_valid) begin
                r_we     <= i_core_we;
                r_funct3 <= i_core_funct3;
                r_addr   <= i_core_addr;
                r_wdata  <= i_core_wdata;
                r_err    <= !w_legal;
            end
            if (r_state == S_WAIT0 && i_mem_rvalid) begin
                r_word0 <= i_mem_rdata;
            end
            if (r_state == S_WAIT1 && i_mem_rvalid) begin
                r_word1 <= i_mem_rdata;
            end
            if (w_done) begin
                r_rdata <= w_result;
            end
        end
    end

    // Stores and rejected requests report zero so the held value is always well defined.
    assign w_result     = (r_we || r_err) ? '0 : w_load_data;

    assign o_core_done  = w_done;
    assign o_core_err   = w_done && r_err;
    assign o_core_rdata = w_done ? w_result : r_rdata;

    assign o_mem_req    = w_req;
    assign o_mem_we     = w_req && r_we;
    assign o_mem_addr   = w_req ? w_beat_addr : '0;
    assign o_mem_be     = w_req ? w_be : 4'b0000;
    assign o_mem_wdata  = w_req ? w_beat_wdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_ready, core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata;
    logic        core_done, core_err;
    logic [31:0] core_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_core_valid(core_valid), .o_core_ready(core_ready), .i_core_we(core_we),
        .i_core_funct3(core_funct3), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_done(core_done), .o_core_err(core_err), .o_core_rdata(core_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
        .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Two memories: one written only by DUT beats, one only by the model.
    logic [7:0] mem_dut [logic [31:0]];
    logic [7:0] mem_ref [logic [31:0]];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5A;
    endfunction
    function automatic logic [7:0] dut_byte(input logic [31:0] a);
        return mem_dut.exists(a) ? mem_dut[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : init_byte(a);
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
        for (int l = 0; l < 4; l++) begin
            mem_dut[a + 32'(l)] = w[8*l +: 8];
            mem_ref[a + 32'(l)] = w[8*l +: 8];
        end
    endtask

    typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { bit err; bit load; logic [31:0] rdata; int cyc; } done_t;
    beat_t exp_beats[$];
    done_t exp_dones[$];

    int gst[2];
    int rdl[2];
    int beat_idx;

    // Memory responder: grant after gst[beat] cycles, rvalid rdl[beat] cycles after the earliest slot.
    initial begin : responder
        int stall_cnt;
        bit rd_pend;
        int rd_cnt;
        logic [31:0] rd_addr;
        stall_cnt = 0; rd_pend = 0; rd_cnt = 0; rd_addr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (rd_pend) begin
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = {dut_byte(rd_addr + 32'd3), dut_byte(rd_addr + 32'd2),
                                 dut_byte(rd_addr + 32'd1), dut_byte(rd_addr)};
                    rd_pend = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end else if (mem_req && !rst) begin
                if (stall_cnt >= gst[beat_idx & 1]) begin
                    mem_gnt = 1'b1;
                    stall_cnt = 0;
                    if (mem_we) begin
                        for (int l = 0; l < 4; l++)
                            if (mem_be[l]) mem_dut[mem_addr + 32'(l)] = mem_wdata[8*l +: 8];
                    end else begin
                        rd_pend = 1'b1;
                        rd_cnt = rdl[beat_idx & 1];
                        rd_addr = mem_addr;
                    end
                    beat_idx++;
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    logic [31:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_wd[$];
    logic [31:0] last_rdata;
    logic        last_err;
    int          done_seen = 0;

    initial begin : monitor
        bit prev_req, prev_gnt;
        logic [31:0] prev_addr, mask;
        beat_t e;
        done_t d;
        prev_req = 0; prev_gnt = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_req = 0;
            end else begin
                if (prev_req && !prev_gnt)
                    chk(mem_req && mem_addr == prev_addr, "req_hold", mem_addr, prev_addr);
                if (mem_req && mem_gnt) begin
                    log_addr.push_back(mem_addr);
                    log_be.push_back(mem_be);
                    log_wd.push_back(mem_wdata);
                    if (exp_beats.size() == 0) begin
                        chk(0, "beat_unexpected", mem_addr, 32'h0);
                    end else begin
                        e = exp_beats.pop_front();
                        mask = {{8{mem_be[3]}}, {8{mem_be[2]}}, {8{mem_be[1]}}, {8{mem_be[0]}}};
                        chk(mem_addr == e.addr, "beat_addr", mem_addr, e.addr);
                        chk(mem_be == e.be, "beat_be", {28'h0, mem_be}, {28'h0, e.be});
                        chk(mem_we == e.we, "beat_we", {31'h0, mem_we}, {31'h0, e.we});
                        if (e.we) chk((mem_wdata & mask) == e.wdata, "beat_wdata", mem_wdata & mask, e.wdata);
                    end
                end
                if (core_done) begin
                    done_seen++;
                    last_rdata = core_rdata;
                    last_err = core_err;
                    if (exp_dones.size() == 0) begin
                        chk(0, "done_unexpected", 32'h1, 32'h0);
                    end else begin
                        d = exp_dones.pop_front();
                        chk(cyc == d.cyc, "done_cycle", cyc, d.cyc);
                        chk(core_err == d.err, "done_err", {31'h0, core_err}, {31'h0, d.err});
                        if (d.load) chk(core_rdata == d.rdata, "load_rdata", core_rdata, d.rdata);
                    end
                end
                prev_req = mem_req;
                prev_gnt = mem_gnt;
                prev_addr = mem_addr;
            end
        end
    end

    task automatic start_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input bit want_done, output int acc);
        int guard, size, nb, lat;
        bit legal;
        done_t d;
        beat_t bt[2];
        guard = 0;
        @(negedge clk);
        while (!core_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!core_ready) chk(0, "ready_timeout", 32'h0, 32'h1);
        legal = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) || (!we && (f3 == 3'b100 || f3 == 3'b101));
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        d.err = !legal;
        d.load = legal && !we;
        d.rdata = '0;
        nb = 0;
        lat = 1;
        if (legal) begin
            for (int b = 0; b < 2; b++) begin
                bt[b].addr = '0; bt[b].be = '0; bt[b].we = we; bt[b].wdata = '0;
            end
            for (int i = 0; i < size; i++) begin
                logic [31:0] a;
                int bi;
                a = addr + 32'(i);
                bi = (a[31:2] == addr[31:2]) ? 0 : 1;
                bt[bi].addr = {a[31:2], 2'b00};
                bt[bi].be[a[1:0]] = 1'b1;
                bt[bi].wdata[8*a[1:0] +: 8] = wd[8*i +: 8];
                if (bi + 1 > nb) nb = bi + 1;
                if (we) mem_ref[a] = wd[8*i +: 8];
                else d.rdata[8*i +: 8] = ref_byte(a);
            end
            if (!we && !f3[2]) begin
                if (size == 1) d.rdata = {{24{d.rdata[7]}}, d.rdata[7:0]};
                if (size == 2) d.rdata = {{16{d.rdata[15]}}, d.rdata[15:0]};
            end
            for (int b = 0; b < nb; b++) begin
                lat += 1 + gst[b] + (we ? 0 : 1 + rdl[b]);
                exp_beats.push_back(bt[b]);
            end
        end
        d.cyc = cyc + lat;
        if (want_done) exp_dones.push_back(d);
        beat_idx = 0;
        core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wd;
        acc = cyc;
        @(posedge clk);
        #1;
        core_valid = 1'b0;
        core_we = 1'($urandom); core_funct3 = 3'($urandom); core_addr = $urandom; core_wdata = $urandom;
        chk(!core_ready, "ready_after_accept", {31'h0, core_ready}, 32'h0);
    endtask

    task automatic wait_done(input int acc, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!core_done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!core_done) begin
            chk(0, "done_timeout", 32'h0, 32'h1);
            lat = -1;
        end else begin
            lat = cyc - acc;
        end
    endtask

    task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat);
        int acc;
        start_txn(we, f3, a, wd, 1'b1, acc);
        wait_done(acc, lat);
        #3;
    endtask

    initial begin : main
        int lat, acc, nbeats, dn, n;
        rst = 1'b1;
        core_valid = 1'b0; core_we = 1'b0; core_funct3 = '0; core_addr = '0; core_wdata = '0;
        gst = '{0, 0};
        rdl = '{0, 0};
        beat_idx = 0;
        repeat (3) @(negedge clk);
        chk(core_ready == 1'b1, "rst_ready", {31'h0, core_ready}, 32'h1);
        chk(mem_req == 1'b0, "rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk(core_done == 1'b0, "rst_done", {31'h0, core_done}, 32'h0);
        chk(core_rdata == 32'h0, "rst_rdata", core_rdata, 32'h0);
        chk(mem_be == 4'h0 && mem_addr == 32'h0, "rst_mem_bus", mem_addr, 32'h0);
        rst = 1'b0;

        poke_word(32'h100, 32'hDEADBEEF);
        run(1'b0, 3'b010, 32'h100, 32'h0, lat);
        chk(lat == 3, "lw_latency", lat, 32'd3);
        chk(last_rdata == 32'hDEADBEEF, "lw_rdata", last_rdata, 32'hDEADBEEF);
        n = log_be.size();
        chk(log_be[n-1] == 4'b1111 && log_addr[n-1] == 32'h100, "lw_beat", log_addr[n-1], 32'h100);

        poke_word(32'h100, 32'h80112233);
        run(1'b0, 3'b000, 32'h103, 32'h0, lat);
        chk(last_rdata == 32'hFFFFFF80, "lb_rdata", last_rdata, 32'hFFFFFF80);
        n = log_be.size();
        chk(log_be[n-1] == 4'b1000, "lb_be", {28'h0, log_be[n-1]}, 32'h8);
        run(1'b0, 3'b100, 32'h103, 32'h0, lat);
        chk(last_rdata == 32'h00000080, "lbu_rdata", last_rdata, 32'h00000080);

        poke_word(32'h104, 32'hAA000000);
        poke_word(32'h108, 32'h000000BB);
        run(1'b0, 3'b001, 32'h107, 32'h0, lat);
        chk(last_rdata == 32'hFFFFBBAA, "lh_split_rdata", last_rdata, 32'hFFFFBBAA);
        chk(lat == 5, "lh_split_latency", lat, 32'd5);
        gst[0] = 3;
        run(1'b0, 3'b001, 32'h107, 32'h0, lat);
        chk(lat == 8, "lh_stall_latency", lat, 32'd8);
        gst[0] = 0;

        run(1'b1, 3'b001, 32'h102, 32'h0000ABCD, lat);
        n = log_be.size();
        chk(lat == 2, "sh_latency", lat, 32'd2);
        chk(log_be[n-1] == 4'b1100 && log_wd[n-1] == 32'hABCD0000, "sh_beat", log_wd[n-1], 32'hABCD0000);

        run(1'b1, 3'b010, 32'h103, 32'h11223344, lat);
        n = log_be.size();
        chk(lat == 3, "sw_split_latency", lat, 32'd3);
        chk(log_addr[n-2] == 32'h100 && log_be[n-2] == 4'b1000, "sw_beat0", log_addr[n-2], 32'h100);
        chk(log_wd[n-2][31:24] == 8'h44, "sw_beat0_data", log_wd[n-2], 32'h44000000);
        chk(log_addr[n-1] == 32'h104 && log_be[n-1] == 4'b0111, "sw_beat1", log_addr[n-1], 32'h104);
        chk(log_wd[n-1][23:0] == 24'h112233, "sw_beat1_data", log_wd[n-1], 32'h00112233);

        nbeats = log_be.size();
        run(1'b0, 3'b011, 32'h100, 32'h0, lat);
        chk(lat == 1 && last_err == 1'b1, "illegal_f3_err", lat, 32'd1);
        run(1'b1, 3'b100, 32'h100, 32'h0, lat);
        chk(last_err == 1'b1, "illegal_store_err", {31'h0, last_err}, 32'h1);
        chk(log_be.size() == nbeats, "illegal_no_traffic", log_be.size(), nbeats);

        poke_word(32'h300, 32'h12345678);
        rdl[0] = 3;
        start_txn(1'b0, 3'b010, 32'h300, 32'h0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk(mem_req == 1'b0 && core_ready == 1'b1, "reset_mid_idle", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        rdl[0] = 0;
        dn = done_seen;
        repeat (8) @(negedge clk);
        chk(done_seen == dn, "reset_no_done", done_seen, dn);
        chk(core_ready == 1'b1 && core_rdata == 32'h0, "reset_idle_rdata", core_rdata, 32'h0);

        for (int k = 0; k < 300; k++) begin
            bit we;
            logic [2:0] f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else a = 32'h200 + 32'($urandom_range(0, 63));
            gst[0] = $urandom_range(0, 2); gst[1] = $urandom_range(0, 2);
            rdl[0] = $urandom_range(0, 2); rdl[1] = $urandom_range(0, 2);
            run(we, f3, a, $urandom, lat);
        end

        chk(exp_beats.size() == 0, "beats_left", exp_beats.size(), 32'h0);
        chk(exp_dones.size() == 0, "dones_left", exp_dones.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
